// File: rtl/eq_stim_checker_pkg.sv
// Shared definitions for the equation stimulus-and-check stage.
//   VEC_W      width of the stimulus vector / vector index
//   state_t    sweep FSM state encoding
//   X*_IDX     position of each equation input x1..x5 inside the x bus
package eq_pkg;

    localparam int VEC_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int X1_IDX = 4;
    localparam int X2_IDX = 3;
    localparam int X3_IDX = 2;
    localparam int X4_IDX = 1;
    localparam int X5_IDX = 0;

endpackage

// File: rtl/eq_stim_checker_if.sv
// Bundle between the stimulus/check stage and its environment.
//   start       sweep request (into the checker)
//   x           stimulus vector driven to the equation block
//   z           equation output returned to the checker
//   busy, done  sweep progress / one-cycle completion pulse
//   err_cnt, fail_valid, first_fail   sweep results
// Modport slave is the checker's view, master is the environment's view.
interface eq_stim_checker_if;
    import eq_pkg::*;

    logic             start;
    logic [VEC_W-1:0] x;
    logic             z;
    logic             busy;
    logic             done;
    logic [5:0]       err_cnt;
    logic             fail_valid;
    logic [VEC_W-1:0] first_fail;

    modport slave (
        input  start,
        input  z,
        output x,
        output busy,
        output done,
        output err_cnt,
        output fail_valid,
        output first_fail
    );

    modport master (
        output start,
        output z,
        input  x,
        input  busy,
        input  done,
        input  err_cnt,
        input  fail_valid,
        input  first_fail
    );

endinterface

// File: rtl/eq_stim_checker_golden.sv
// Combinational golden model of the five-input equation block:
//   z = ~((x1 & x2) | (x3 & x4 & x5))
// Ports:
//   x      in  5  stimulus vector (x[4]=x1 ... x[0]=x5)
//   z_exp  out 1  expected equation output
module eq_golden
    import eq_pkg::*;
(
    input  logic [VEC_W-1:0] x,
    output logic             z_exp
);

    // Expected value of the equation for the current vector
    always_comb begin
        z_exp = ~((x[X1_IDX] & x[X2_IDX]) | (x[X3_IDX] & x[X4_IDX] & x[X5_IDX]));
    end

endmodule

// File: rtl/eq_stim_checker.sv
// Clocked stimulus-and-check stage around the five-input equation block.
// Sweeps vectors 0..N_VEC-1 onto x, holds each for SETTLE cycles, samples z
// in a one-cycle SAMPLE state and compares it with the golden model.
// Parameters:
//   N_VEC   number of vectors swept (1..32)
//   SETTLE  cycles each vector is held before its sample cycle (1..15)
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   eq_stim_checker_if.slave: start, z in; x, busy, done, err_cnt,
//         fail_valid, first_fail out (all outputs registered)
module eq_stim_checker
    import eq_pkg::*;
#(
    parameter int N_VEC  = 32,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    eq_stim_checker_if.slave    bus
);

    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(N_VEC - 1);
    localparam logic [3:0]       LAST_SETTLE = 4'(SETTLE - 1);

    state_t           state_r;
    logic [VEC_W-1:0] vec_r;
    logic [3:0]       settle_r;
    logic             busy_r;
    logic             done_r;
    logic [5:0]       err_cnt_r;
    logic             fail_valid_r;
    logic [VEC_W-1:0] first_fail_r;
    logic             z_exp_s;
    logic             mismatch_s;

    // vec_r doubles as the x register: it is cleared whenever no vector is driven
    eq_golden u_golden (
        .x     (vec_r),
        .z_exp (z_exp_s)
    );

    // Compare the returned equation output with the golden value
    always_comb begin
        mismatch_s = (bus.z != z_exp_s);
    end

    // Sweep FSM, vector/settle counters and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            vec_r        <= '0;
            settle_r     <= 4'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_cnt_r    <= 6'd0;
            fail_valid_r <= 1'b0;
            first_fail_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r      <= DRIVE;
                        vec_r        <= '0;
                        settle_r     <= 4'd0;
                        busy_r       <= 1'b1;
                        err_cnt_r    <= 6'd0;
                        fail_valid_r <= 1'b0;
                        first_fail_r <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DRIVE: begin
                    if (settle_r == LAST_SETTLE) begin
                        state_r  <= SAMPLE;
                        settle_r <= 4'd0;
                    end else begin
                        settle_r <= settle_r + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch_s) begin
                        err_cnt_r <= err_cnt_r + 6'd1;
                        // Only the first mismatch of the sweep is latched
                        if (!fail_valid_r) begin
                            first_fail_r <= vec_r;
                            fail_valid_r <= 1'b1;
                        end else begin
                            first_fail_r <= first_fail_r;
                        end
                    end else begin
                        err_cnt_r <= err_cnt_r;
                    end
                    if (vec_r == LAST_VEC) begin
                        state_r <= DONE;
                        vec_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRIVE;
                        vec_r   <= vec_r + VEC_W'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    vec_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x          = vec_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err_cnt    = err_cnt_r;
    assign bus.fail_valid = fail_valid_r;
    assign bus.first_fail = first_fail_r;

endmodule

// File: doc/eq_stim_checker.md
# eq_stim_checker

- Sequential stimulus-and-check stage that sits directly around the five-input `equation` block (z = ~((x1 & x2) | (x3 & x4 & x5))).
- Drives the equation's x1..x5 inputs from an internal vector counter, waits a programmable settle time, then samples z.
- Compares each sample against a golden model and reports an error count and the first failing vector.
- Replaces hand-written `#10` stimulus with a self-checking, clocked sweep.

## Interface

Parameters:
- `N_VEC`, default 32: number of vectors swept, 0..N_VEC-1. Legal range 1..32.
- `SETTLE`, default 1: cycles each vector is held before its sample cycle. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `x`  out  5  stimulus to the equation block. Bit mapping: x[4]=x1, x[3]=x2, x[2]=x3, x[1]=x4, x[0]=x5.
- `z`  in  1  equation output under check.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `err_cnt`  out  6  number of mismatching vectors in the last sweep (0..32).
- `fail_valid`  out  1  high once at least one mismatch has been recorded in the current or last sweep.
- `first_fail`  out  5  vector index of the first mismatch; meaningful only when `fail_valid`=1.

## Operation

- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- **IDLE**
  - `start`=1 moves to DRIVE.
  - On that transition: vec←0, settle count←0, err_cnt←0, fail_valid←0, first_fail←0.
- **DRIVE**
  - x = vec, held constant.
  - Lasts exactly SETTLE cycles, then moves to SAMPLE.
- **SAMPLE** (1 cycle, x unchanged)
  - expected = ~((x[4]&x[3]) | (x[2]&x[1]&x[0])).
  - If z ≠ expected: err_cnt increments. If fail_valid=0, first_fail←vec and fail_valid←1.
  - If vec = N_VEC-1, move to DONE; otherwise vec←vec+1 and return to DRIVE.
- **DONE** (1 cycle)
  - `done`=1, then move to IDLE.
  - x returns to 0 in IDLE.
- `start` is ignored in DRIVE, SAMPLE and DONE. It is not queued.
- err_cnt, fail_valid and first_fail hold their values in IDLE until the next accepted `start`.
- err_cnt cannot exceed N_VEC, so no saturation logic is needed. Width stays 6 so the value 32 is representable.

## Timing

- All outputs are registered.
- Reset values: x=0, busy=0, done=0, err_cnt=0, fail_valid=0, first_fail=0, state=IDLE.
- Reset mid-sweep: immediate return to the reset values, with no `done` pulse. The next `start` begins again at vector 0.
- Sweep timing, with `start` sampled high at edge E0:
  - busy=1 and x=0 from E0.
  - Vector k is driven during cycles E0+k·(SETTLE+1) through E0+(k+1)·(SETTLE+1)-1.
  - z is captured at the last of those edges.
  - At edge E0+N_VEC·(SETTLE+1): busy=0 and done=1 for one cycle. err_cnt and first_fail are final from that edge.
- Busy duration is N_VEC·(SETTLE+1) cycles. Defaults give 64 cycles.
- Combinational path from x back to z must settle within SETTLE cycles. The block does not register z separately.

## Structure

- Shared package `eq_pkg` holds:
  - VEC_W=5;
  - the FSM state enum (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - the x-bit-to-x1..x5 index constants.
- Sub-module `eq_golden`: combinational expected-value model, 5-bit in, 1-bit out. It also serves as the bench's reference model.
- Top level contains the FSM, vec counter, settle counter and result registers.

## Test plan

- **Correct equation, defaults:** connect the real equation block and pulse start → busy 64 cycles, done pulse at cycle 64, err_cnt=0, fail_valid=0.
- **z stuck-at-0:** → err_cnt=21, fail_valid=1, first_fail=0.
- **z stuck-at-1:** → err_cnt=11, first_fail=7 (x=00111, where x3x4x5=1).
- **start held high through a sweep, plus a 1-cycle start pulse in DRIVE:** → single sweep only, one done pulse, then a new sweep begins the cycle after IDLE is re-entered, because start is still high.
- **rst asserted during vector 10:** → all outputs 0 immediately, no done pulse. A subsequent start sweeps from vector 0 and ends with err_cnt=0.
- **N_VEC=4, SETTLE=2, correct equation:** → x steps 0,1,2,3 with each value held 3 cycles, busy 12 cycles, err_cnt=0.
